// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared core definitions for the memory-access (MEM) pipeline stage:
//   mem_oper_t  - memory operation carried in the EX/MEM register
//   mem_state_t - bus-access FSM state of the MEM stage
//   BUBBLE_*    - values loaded into the MEM/WB register for a bubble
// Helper functions classify an operation and detect misalignment.
// ---------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_oper_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,  // no access outstanding
        MS_REQ  = 2'd1,  // request on the bus, not yet granted
        MS_RESP = 2'd2   // load granted, waiting for rvalid
    } mem_state_t;

    localparam logic        BUBBLE_WB_USE_MEM = 1'b0;
    localparam logic        BUBBLE_WRITE_RD   = 1'b0;
    localparam logic [4:0]  BUBBLE_RD_ADDR    = 5'd0;
    localparam logic [31:0] BUBBLE_DATA       = 32'd0;

    function automatic logic op_is_load(input mem_oper_t op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic op_is_store(input mem_oper_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic op_misaligned(input mem_oper_t op, input logic [1:0] off);
        logic half;
        logic word;
        half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word = (op == MEM_LW) || (op == MEM_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the MEM stage.
//   i_oper       - memory operation
//   i_off        - byte offset within the word (address bits [1:0])
//   i_store_data - rs2 store data
//   i_rdata      - load word from the data bus
//   o_be         - byte enables (stores by size/offset, loads all four)
//   o_wdata      - store data replicated across the byte lanes
//   o_load_data  - extracted and sign/zero-extended load result, 0 for non-loads
// ---------------------------------------------------------------------------
module lsu_align
    import mem_access_pkg::*;
(
    input  mem_oper_t   i_oper,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        case (i_oper)
            MEM_SB: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_store_data[7:0]}};
            end
            MEM_SH: begin
                // Only off[1] selects the half; off[0] is ignored here.
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_load_data = 32'd0;
        case (i_oper)
            MEM_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_load_data = {24'd0, w_byte};
            MEM_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_load_data = {16'd0, w_half};
            MEM_LW:  o_load_data = i_rdata;
            default: o_load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// MEM pipeline stage: drives the data-memory bus for loads/stores, stalls
// the pipeline while an access is outstanding, and holds the MEM/WB register.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses (no bus request, one-cycle misaligned_o pulse, bubble to WB).
//
// Ports
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   alu_result_i, store_data_i address and store data from EX/MEM
//   mem_oper_i                 memory operation from EX/MEM
//   wb_use_mem_i, write_rd_i, rd_addr_i  WB controls from EX/MEM
//   flush_i                    load a bubble into MEM/WB
//   dmem_*                     data-memory bus
//     handshake: dmem_req_o with we/be/addr/wdata is held stable until a
//     cycle with dmem_gnt_i=1, which accepts it; a granted load returns its
//     word in a later cycle with dmem_rvalid_i=1 (never in the gnt cycle).
//   mem_busy_o                 stall request: the access does not finish now
//   misaligned_o               misaligned-access pulse (trap build only)
//   wb_use_mem_o, write_rd_o, rd_addr_o, alu_result_o, load_data_o  MEM/WB
//   dbg_state_o                current FSM state
// ---------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  mem_oper_t   mem_oper_i,
    input  logic        wb_use_mem_i,
    input  logic        write_rd_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_busy_o,
    output logic        misaligned_o,
    output logic        wb_use_mem_o,
    output logic        write_rd_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] load_data_o,
    output mem_state_t  dbg_state_o
);

    mem_state_t  r_state;
    logic        r_kill;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic        w_trap;
    logic        w_req;
    logic        w_busy;
    logic        w_bubble;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_is_load  = op_is_load(mem_oper_i);
    assign w_is_store = op_is_store(mem_oper_i);
    assign w_access   = w_is_load || w_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = (r_state == MS_IDLE) && op_misaligned(mem_oper_i, alu_result_i[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // The EX/MEM register is frozen by mem_busy_o, so the bus fields stay
    // stable while waiting for gnt simply by being driven from its outputs.
    // Everything is gated by rstn_i so reset clears the bus at once.
    assign w_req = rstn_i && (((r_state == MS_IDLE) && w_access && !w_trap) ||
                              (r_state == MS_REQ));

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            MS_IDLE: w_busy = w_access && !w_trap && !(w_is_store && dmem_gnt_i);
            MS_REQ:  w_busy = !(w_is_store && dmem_gnt_i);
            MS_RESP: w_busy = !dmem_rvalid_i;
            default: w_busy = 1'b0;
        endcase
        if (!rstn_i) begin
            w_busy = 1'b0;
        end
    end

    lsu_align u_lsu_align (
        .i_oper       (mem_oper_i),
        .i_off        (alu_result_i[1:0]),
        .i_store_data (store_data_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign dmem_req_o   = w_req;
    assign dmem_we_o    = w_req && w_is_store;
    assign dmem_be_o    = w_req ? w_be : 4'd0;
    assign dmem_addr_o  = w_req ? {alu_result_i[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_o = (w_req && w_is_store) ? w_wdata : 32'd0;
    assign mem_busy_o   = w_busy;
    assign misaligned_o = rstn_i && w_trap;
    assign dbg_state_o  = r_state;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= MS_IDLE;
        end else begin
            case (r_state)
                MS_IDLE: begin
                    if (w_req) begin
                        if (!dmem_gnt_i)    r_state <= MS_REQ;
                        else if (w_is_load) r_state <= MS_RESP;
                        else                r_state <= MS_IDLE;
                    end
                end
                MS_REQ: begin
                    if (dmem_gnt_i) r_state <= w_is_load ? MS_RESP : MS_IDLE;
                end
                MS_RESP: begin
                    if (dmem_rvalid_i) r_state <= MS_IDLE;
                end
                default: r_state <= MS_IDLE;
            endcase
        end
    end

    // A flush seen while the access is still stalled must also kill its
    // eventual writeback; remember it until the access completes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_kill <= 1'b0;
        end else begin
            r_kill <= w_busy && (r_kill || flush_i);
        end
    end

    assign w_bubble = w_busy || w_trap || flush_i || r_kill;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_use_mem_o <= BUBBLE_WB_USE_MEM;
            write_rd_o   <= BUBBLE_WRITE_RD;
            rd_addr_o    <= BUBBLE_RD_ADDR;
            alu_result_o <= BUBBLE_DATA;
            load_data_o  <= BUBBLE_DATA;
        end else if (w_bubble) begin
            wb_use_mem_o <= BUBBLE_WB_USE_MEM;
            write_rd_o   <= BUBBLE_WRITE_RD;
            rd_addr_o    <= BUBBLE_RD_ADDR;
            alu_result_o <= BUBBLE_DATA;
            load_data_o  <= BUBBLE_DATA;
        end else begin
            wb_use_mem_o <= wb_use_mem_i;
            write_rd_o   <= write_rd_i;
            rd_addr_o    <= rd_addr_i;
            alu_result_o <= alu_result_i;
            load_data_o  <= w_load_data;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Drives mem_access one transaction at a time while acting as the memory.
// Each transaction has a known grant delay and response delay, so the bench
// knows, for every cycle, what the bus, stall and MEM/WB outputs must be.
// ---------------------------------------------------------------------------
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    mem_oper_t   mem_oper_i;
    logic        wb_use_mem_i;
    logic        write_rd_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        mem_busy_o;
    logic        misaligned_o;
    logic        wb_use_mem_o;
    logic        write_rd_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] alu_result_o;
    logic [31:0] load_data_o;
    mem_state_t  dbg_state_o;

    always #5 clk_i = ~clk_i;

    mem_access dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .alu_result_i  (alu_result_i),
        .store_data_i  (store_data_i),
        .mem_oper_i    (mem_oper_i),
        .wb_use_mem_i  (wb_use_mem_i),
        .write_rd_i    (write_rd_i),
        .rd_addr_i     (rd_addr_i),
        .flush_i       (flush_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .mem_busy_o    (mem_busy_o),
        .misaligned_o  (misaligned_o),
        .wb_use_mem_o  (wb_use_mem_o),
        .write_rd_o    (write_rd_o),
        .rd_addr_o     (rd_addr_o),
        .alu_result_o  (alu_result_o),
        .load_data_o   (load_data_o),
        .dbg_state_o   (dbg_state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // expected values for the current cycle
    logic        e_req, e_we, e_busy, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    mem_state_t  e_state;
    logic        e_wbm, e_wrd;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_is_load(input mem_oper_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic m_is_store(input mem_oper_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic m_trap(input mem_oper_t op, input logic [1:0] off);
`ifdef MEM_MISALIGN_TRAP_EN
        if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return (off % 2) != 0;
        if (op inside {MEM_LW, MEM_SW})          return off != 2'd0;
        return 1'b0;
`else
        return (op == MEM_NOP) && (off == 2'd3) && 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input mem_oper_t op, input logic [1:0] off);
        int unsigned o;
        o = 32'(off);
        if (op == MEM_SB) return 4'(1 << o);
        if (op == MEM_SH) return 4'(3 << (o & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input mem_oper_t op, input logic [31:0] d);
        if (op == MEM_SB) return 32'(d[7:0]) * 32'h0101_0101;
        if (op == MEM_SH) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input mem_oper_t op, input logic [1:0] off, input logic [31:0] d);
        int unsigned o, b, h;
        o = 32'(off);
        b = (d >> (8 * o)) & 32'hFF;
        h = (d >> (16 * (o / 2))) & 32'hFFFF;
        case (op)
            MEM_LB:  return (b >= 128)    ? b + 32'hFFFF_FF00 : b;
            MEM_LBU: return b;
            MEM_LH:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            MEM_LHU: return h;
            MEM_LW:  return d;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("dmem_req",   32'(dmem_req_o),   32'(e_req));
            check("dmem_we",    32'(dmem_we_o),    32'(e_we));
            check("dmem_be",    32'(dmem_be_o),    32'(e_be));
            check("dmem_addr",  dmem_addr_o,       e_addr);
            check("dmem_wdata", dmem_wdata_o,      e_wdata);
            check("mem_busy",   32'(mem_busy_o),   32'(e_busy));
            check("misaligned", 32'(misaligned_o), 32'(e_mis));
            check("state",      32'(dbg_state_o),  32'(e_state));
            check("wb_use_mem", 32'(wb_use_mem_o), 32'(e_wbm));
            check("write_rd",   32'(write_rd_o),   32'(e_wrd));
            check("rd_addr",    32'(rd_addr_o),    32'(e_rd));
            check("alu_result", alu_result_o,      e_alu);
            check("load_data",  load_data_o,       e_ld);
        end
    end

    // ---------------- driver ----------------
    // gdly: cycles before gnt; rdly: extra cycles after gnt+1 before rvalid;
    // flush_k: cycle index of a flush pulse, -1 for none.
    task automatic do_txn(input mem_oper_t op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic wbm, input logic wrd,
                          input int gdly, input int rdly, input logic [31:0] rdata, input int flush_k);
        logic ld, st, trap, acc, killed, fl;
        int   last;
        ld     = m_is_load(op);
        st     = m_is_store(op);
        trap   = (ld || st) && m_trap(op, addr[1:0]);
        acc    = (ld || st) && !trap;
        last   = !acc ? 0 : (st ? gdly : gdly + 1 + rdly);
        killed = 1'b0;
        for (int k = 0; k <= last; k++) begin
            fl            = (k == flush_k);
            mem_oper_i    = op;
            alu_result_i  = addr;
            store_data_i  = sdata;
            rd_addr_i     = rd;
            wb_use_mem_i  = wbm;
            write_rd_i    = wrd;
            flush_i       = fl;
            dmem_gnt_i    = acc && (k == gdly);
            dmem_rvalid_i = acc && ld && (k == gdly + 1 + rdly);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom();
            e_req   = acc && (k <= gdly);
            e_we    = e_req && st;
            e_be    = e_req ? m_be(op, addr[1:0]) : 4'd0;
            e_addr  = e_req ? (addr & 32'hFFFF_FFFC) : 32'd0;
            e_wdata = e_we ? m_wdata(op, sdata) : 32'd0;
            e_busy  = acc && (k < last);
            e_mis   = trap;
            e_state = (k == 0) ? MS_IDLE : ((k <= gdly) ? MS_REQ : MS_RESP);
            killed  = killed || fl;
            @(posedge clk_i);
            #1;
            if ((k == last) && !killed && !trap) begin
                e_wbm = wbm; e_wrd = wrd; e_rd = rd; e_alu = addr;
                e_ld  = ld ? m_load(op, addr[1:0], rdata) : 32'd0;
            end else begin
                e_wbm = 1'b0; e_wrd = 1'b0; e_rd = 5'd0; e_alu = 32'd0; e_ld = 32'd0;
            end
        end
    endtask

    task automatic clear_exp();
        e_req = 0; e_we = 0; e_busy = 0; e_mis = 0; e_be = 0; e_addr = 0; e_wdata = 0;
        e_state = MS_IDLE; e_wbm = 0; e_wrd = 0; e_rd = 0; e_alu = 0; e_ld = 0;
    endtask

    task automatic drive_idle();
        mem_oper_i = MEM_NOP; alu_result_i = 0; store_data_i = 0; wb_use_mem_i = 0;
        write_rd_i = 0; rd_addr_i = 0; flush_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
        dmem_rdata_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   32'(dmem_req_o),   32'd0);
        check({tag, "_busy"},  32'(mem_busy_o),   32'd0);
        check({tag, "_mis"},   32'(misaligned_o), 32'd0);
        check({tag, "_be"},    32'(dmem_be_o),    32'd0);
        check({tag, "_state"}, 32'(dbg_state_o),  32'(MS_IDLE));
        check({tag, "_wrd"},   32'(write_rd_o),   32'd0);
        check({tag, "_wbm"},   32'(wb_use_mem_o), 32'd0);
        check({tag, "_rd"},    32'(rd_addr_o),    32'd0);
        check({tag, "_alu"},   alu_result_o,      32'd0);
        check({tag, "_ld"},    load_data_o,       32'd0);
    endtask

    // Load granted immediately, then reset asserted while it waits in RESP.
    task automatic reset_in_resp();
        do_txn(MEM_NOP, 32'h1234_5678, 32'd0, 5'd9, 1'b0, 1'b1, 0, 0, 32'd0, -1);
        mem_oper_i = MEM_LW; alu_result_i = 32'h40; write_rd_i = 1; rd_addr_i = 7;
        wb_use_mem_i = 1; flush_i = 0; dmem_gnt_i = 1; dmem_rvalid_i = 0;
        e_req = 1; e_we = 0; e_be = 4'hF; e_addr = 32'h40; e_wdata = 0; e_busy = 1;
        e_mis = 0; e_state = MS_IDLE;
        @(posedge clk_i);
        #1;
        dmem_gnt_i = 0;
        e_req = 0; e_be = 0; e_addr = 0; e_state = MS_RESP;
        e_wbm = 0; e_wrd = 0; e_rd = 0; e_alu = 0; e_ld = 0;
        @(negedge clk_i);
        #2;
        chk_en = 1'b0;
        check("resp_state_before_rst", 32'(dbg_state_o), 32'(MS_RESP));
        rstn_i = 1'b0;
        #1;
        check_all_zero("rst_in_resp");
        @(posedge clk_i);
        #1;
        check_all_zero("rst_held");
        drive_idle();
        rstn_i = 1'b1;
        clear_exp();
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete (n_bad=%0d)", n_bad);
        $fatal(1);
    end

    initial begin
        mem_oper_t op;
        logic [31:0] a;
        int fk;
        drive_idle();
        clear_exp();
        rstn_i = 1'b1;
        #2 rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");

        // model pins
        check("pin_sw_be",   32'(m_be(MEM_SW, 2'd0)),             32'h0000_000F);
        check("pin_sh_be",   32'(m_be(MEM_SH, 2'd2)),             32'h0000_000C);
        check("pin_sh_wd",   m_wdata(MEM_SH, 32'h0000_ABCD),      32'hABCD_ABCD);
        check("pin_lb",      m_load(MEM_LB, 2'd3, 32'h80FF_FFFF),  32'hFFFF_FF80);
        check("pin_lbu",     m_load(MEM_LBU, 2'd3, 32'h80FF_FFFF), 32'h0000_0080);
        check("pin_lh",      m_load(MEM_LH, 2'd2, 32'h8001_0000),  32'hFFFF_8001);

        rstn_i = 1'b1;
        chk_en = 1'b1;

        do_txn(MEM_SW, 32'h100, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, 0, 0, 32'd0, -1);
        check("sw_state_after", 32'(dbg_state_o), 32'(MS_IDLE));

        do_txn(MEM_LB, 32'h203, 32'd0, 5'd5, 1'b1, 1'b1, 2, 0, 32'h80FF_FFFF, -1);
        check("lb_lit_data", load_data_o, 32'hFFFF_FF80);
        check("lb_lit_wrd",  32'(write_rd_o), 32'd1);
        do_txn(MEM_LBU, 32'h203, 32'd0, 5'd5, 1'b1, 1'b1, 2, 0, 32'h80FF_FFFF, -1);
        check("lbu_lit_data", load_data_o, 32'h0000_0080);

        do_txn(MEM_SH, 32'h102, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1, 0, 32'd0, -1);

        do_txn(MEM_LW, 32'h300, 32'd0, 5'd11, 1'b1, 1'b1, 0, 2, 32'hCAFE_F00D, 1);
        check("flushed_lw_wrd",   32'(write_rd_o),  32'd0);
        check("flushed_lw_state", 32'(dbg_state_o), 32'(MS_IDLE));

`ifdef MEM_MISALIGN_TRAP_EN
        do_txn(MEM_LW, 32'h101, 32'd0, 5'd4, 1'b1, 1'b1, 0, 0, 32'd0, -1);
        check("trap_lw_wrd", 32'(write_rd_o), 32'd0);
`endif

        reset_in_resp();

        for (int i = 0; i < 200; i++) begin
            op = mem_oper_t'($urandom_range(0, 8));
            a  = $urandom();
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            fk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            do_txn(op, a, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom(), fk);
        end

        drive_idle();
        @(negedge clk_i);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
